// File: rtl/universal_shift_pkg.sv
// -----------------------------------------------------------------------------
// universal_shift_pkg
//   Shared definitions for universal_shift_ctrl and universal_shift_reg.
//   Both sides decode the same 2-bit mode word, so its encoding lives here once.
//   Contents:
//     mode_t     : register operation (hold / shift right / shift left / load)
//     state_t    : controller sequencing states
//     dir_mode() : maps the latched direction bit onto the shift mode
// -----------------------------------------------------------------------------
package universal_shift_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // dir = 0 moves bits toward bit 0 (right), dir = 1 toward bit N-1 (left).
    function automatic mode_t dir_mode(input logic dir);
        return dir ? MODE_SHL : MODE_SHR;
    endfunction

endpackage

// File: rtl/universal_shift_ctrl_if.sv
// -----------------------------------------------------------------------------
// universal_shift_ctrl_if
//   Host-side transfer bus of universal_shift_ctrl.
//   Signals:
//     start       host -> ctrl  transfer request, sampled only in IDLE
//     abort       host -> ctrl  cancel a transfer in LOAD/SHIFT
//     dir         host -> ctrl  0 = shift right, 1 = shift left
//     shift_count host -> ctrl  number of shifts C (clamped to N)
//     din_word    host -> ctrl  word to parallel-load
//     ser_in      host -> ctrl  serial bit fed into the vacated end
//     ser_out     ctrl -> host  bit leaving the register this cycle
//     busy        ctrl -> host  high in LOAD and SHIFT
//     done        ctrl -> host  one-cycle completion pulse
//     dout_word   ctrl -> host  register value captured at completion
//   Modports: master = host, slave = controller.
//   N and CNT_W must match the controller instance they connect to.
// -----------------------------------------------------------------------------
interface universal_shift_ctrl_if #(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) ();

    logic             start;
    logic             abort;
    logic             dir;
    logic [CNT_W-1:0] shift_count;
    logic [N-1:0]     din_word;
    logic             ser_in;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic [N-1:0]     dout_word;

    modport master (
        output start, abort, dir, shift_count, din_word, ser_in,
        input  ser_out, busy, done, dout_word
    );

    modport slave (
        input  start, abort, dir, shift_count, din_word, ser_in,
        output ser_out, busy, done, dout_word
    );

endinterface

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
//   N-bit universal shift register driven by universal_shift_ctrl.
//   Ports:
//     clk               in   rising-edge clock
//     reset             in   synchronous, active-low reset (clears q)
//     i_mode            in   00 hold, 01 right, 10 left, 11 load
//     i_parallel_in     in   N-bit load value
//     i_serial_in_left  in   bit entering at q[N-1] on a right shift
//     i_serial_in_right in   bit entering at q[0] on a left shift
//     o_q               out  register contents
// -----------------------------------------------------------------------------
module universal_shift_reg
    import universal_shift_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   i_mode,
    input  logic [N-1:0] i_parallel_in,
    input  logic         i_serial_in_left,
    input  logic         i_serial_in_right,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else begin
            case (mode_t'(i_mode))
                MODE_SHR:  r_q <= {i_serial_in_left, r_q[N-1:1]};
                MODE_SHL:  r_q <= {r_q[N-2:0], i_serial_in_right};
                MODE_LOAD: r_q <= i_parallel_in;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/universal_shift_ctrl.sv
// -----------------------------------------------------------------------------
// universal_shift_ctrl
//   Sequencer for universal_shift_reg: one accepted start becomes
//   LOAD (1 cycle) -> SHIFT (C cycles) -> DONE (1 cycle) -> IDLE.
//   Ports:
//     clk               in   rising-edge clock
//     reset             in   synchronous, active-low reset
//     bus               --   host transfer bus (universal_shift_ctrl_if.slave)
//     i_q               in   register contents (universal_shift_reg.o_q)
//     o_mode            out  register mode, decoded from registered state only
//     o_parallel_in     out  word latched at accept
//     o_serial_in_left  out  ser_in during a right shift, else 0
//     o_serial_in_right out  ser_in during a left shift, else 0
//   Parameters:
//     N      register width, must match universal_shift_reg
//     CNT_W  width of shift_count and the internal down-counter
// -----------------------------------------------------------------------------
module universal_shift_ctrl
    import universal_shift_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    universal_shift_ctrl_if.slave  bus,
    input  logic [N-1:0]           i_q,
    output logic [1:0]             o_mode,
    output logic [N-1:0]           o_parallel_in,
    output logic                   o_serial_in_left,
    output logic                   o_serial_in_right
);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_word;
    logic             r_dir;
    logic [N-1:0]     r_dout;

    logic             w_accept;
    logic [CNT_W-1:0] w_count_clamped;
    mode_t            w_mode;
    logic             w_busy;
    logic             w_done;
    logic             w_ser_out;
    logic             w_sil;
    logic             w_sir;

    // A request is taken only in IDLE and only without a simultaneous abort.
    assign w_accept        = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_count_clamped = (bus.shift_count > CNT_W'(N)) ? CNT_W'(N) : bus.shift_count;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_word  <= '0;
            r_dir   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    // Transfer parameters are frozen here; later input
                    // changes cannot disturb a transfer in flight.
                    if (w_accept) begin
                        r_word <= bus.din_word;
                        r_dir  <= bus.dir;
                        r_cnt  <= w_count_clamped;
                    end
                end
                ST_SHIFT: r_cnt <= r_cnt - CNT_W'(1);
                // Capture on the edge leaving DONE, after the final shift
                // has landed in the register.
                ST_DONE:  r_dout <= i_q;
                default:  ;
            endcase
        end
    end

    // ----------------------------------------------------------- next state
    // NOTE: every always_comb output gets a default first, so no path through
    // the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.abort)          w_next_state = ST_IDLE;
                else if (r_cnt == '0)   w_next_state = ST_DONE;
                else                    w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                // r_cnt holds the shifts still to do including this cycle.
                if (bus.abort)                 w_next_state = ST_IDLE;
                else if (r_cnt == CNT_W'(1))   w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // mode/busy/done depend on registered state only, so an abort takes
    // effect on the register one cycle later (the abort cycle still shifts).
    always_comb begin
        w_mode    = MODE_HOLD;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        w_ser_out = 1'b0;
        w_sil     = 1'b0;
        w_sir     = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                w_mode = MODE_LOAD;
                w_busy = 1'b1;
            end
            ST_SHIFT: begin
                w_mode    = dir_mode(r_dir);
                w_busy    = 1'b1;
                w_ser_out = r_dir ? i_q[N-1] : i_q[0];
                w_sil     = r_dir ? 1'b0 : bus.ser_in;
                w_sir     = r_dir ? bus.ser_in : 1'b0;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign o_mode            = w_mode;
    assign o_parallel_in     = r_word;
    assign o_serial_in_left  = w_sil;
    assign o_serial_in_right = w_sir;

    assign bus.ser_out   = w_ser_out;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.dout_word = r_dout;

endmodule
